cpu_resp_tx: RTL and testbench
==============================

// Module: cpu_resp_tx
// PURPOSE
//  Response transmitter: the cache-to-CPU return path for requests carried in cpu_raw_request_t.
//  Takes completed pipe3_t entries from the last pipeline stage, builds a CPU response
//  (req_id, op, data, status), buffers it in a DEPTH-entry FIFO and drives it to the CPU over
//  a valid/ready channel. Backpressures the pipeline via in_ready when the FIFO is full.
// PARAMETERS
//  DEPTH      4   response FIFO entries; power of 2, >= 2
//  CNT_WIDTH  16  width of the sent-response counter
//  Data, request-ID and op widths come from design_params: DATA_WIDTH, REQ_ID and OP.
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               synchronous active-low reset
//  in_valid       in   1               pipe3 entry present
//  in_ready       out  1               entry accepted this cycle when in_valid & in_ready
//  in_req         in   $bits(pipe3_t)  pipe3 stage payload
//  in_rd_data     in   DATA_WIDTH      data-array read word for in_req, valid with in_valid
//  resp_valid     out  1               response at FIFO head
//  resp_ready     in   1               CPU accepts response
//  resp_req_id    out  REQ_ID          echoed raw_req.req_id
//  resp_op        out  OP              echoed raw_req.op
//  resp_data      out  DATA_WIDTH      read data (READ) / 0 (otherwise)
//  resp_status    out  2               00 hit, 01 miss serviced, 10 bad op
//  dup_id_err     out  1               sticky: pushed req_id already queued
//  resp_count     out  CNT_WIDTH       responses delivered, wraps
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//  - FIFO emptied (ptrs/count = 0); dup_id_err = 0; resp_count = 0.
//  - resp_valid = 0. resp_* fields = 0 (head entry storage is cleared).
//  - Mid-operation reset discards all queued responses; no partial handshake survives.
//  Op encoding: 2'd0 READ, 2'd1 WRITE, 2'd2/2'd3 reserved.
//  Push:
//  - in_ready = !full & in_req.ready_to_send (combinational). full = (count == DEPTH).
//  - An entry with ready_to_send = 0 is held off: in_ready = 0, nothing is queued.
//  - On push, store {req_id, op, data, status}:
//    - data = in_rd_data if op == READ, else 0.
//    - status = 10 if op is reserved; else 00 if the pipe1 hit bit is set; else 01.
//    - For bad ops data is forced to 0.
//  Pop:
//  - resp_valid = !empty. The head is stable while resp_valid & !resp_ready.
//  - On resp_valid & resp_ready: pop, and resp_count += 1 modulo 2^CNT_WIDTH.
//  Latency:
//  - A push in cycle N into an empty FIFO gives resp_valid = 1 in cycle N+1.
//  - There is no same-cycle bypass.
//  Simultaneous push and pop:
//  - Allowed when not full; count is unchanged and ptrs advance, wrapping modulo DEPTH.
//  - When full, in_ready = 0 even if a pop occurs that cycle.
//  - Push while empty is legal; the pop is not (resp_valid = 0).
//  Duplicate ID:
//  - If the pushed req_id equals the req_id of any valid queued entry that is not popped
//    the same cycle, set dup_id_err = 1.
//  - The entry is still queued. dup_id_err clears only on reset.
//  Pointers: log2(DEPTH)-bit read/write ptrs plus a count of log2(DEPTH)+1 bits.
// TESTING
//  T1 reset:
//  - Hold rst_n=0 for 2 clk with in_valid=1.
//  - Expect resp_valid=0, in_ready=0 during reset, resp_count=0, dup_id_err=0.
//  T2 read hit:
//  - Push op=0, req_id=3, hit=1, ready_to_send=1, in_rd_data=32'hDEADBEEF.
//  - Next cycle expect resp_valid=1, resp_req_id=3, resp_data=DEADBEEF, status=00.
//  - After pop, expect resp_count=1.
//  T3 backpressure:
//  - Hold resp_ready=0 and push 5 entries (ids 0..4).
//  - in_ready drops after 4; id 4 is held.
//  - Then resp_ready=1: responses arrive in order 0..4, and ptrs wrap.
//  T4 write / bad op:
//  - Push op=1, miss, data in 0x55; then op=3.
//  - Expect (data=0, status=01), then (data=0, status=10).
//  T5 hold-off and duplicate:
//  - Push ready_to_send=0: in_ready=0 and no response.
//  - Then queue id 2 twice with resp_ready=0: dup_id_err=1 and stays 1 after drain.
//  T6 push+pop same cycle:
//  - With 1 entry queued, push and pop together.
//  - count stays 1, resp_count increments, and the order is preserved.

Source files
------------

// File: rtl/design_params.sv
// Shared widths and pipeline payload types for the cache-to-CPU response path.
package design_params;
   localparam int DATA_WIDTH = 32;
   localparam int REQ_ID     = 4;
   localparam int OP         = 2;

   typedef struct packed {
      logic [REQ_ID-1:0] req_id;
      logic [OP-1:0]     op;
   } cpu_raw_request_t;

   typedef struct packed {
      logic hit;
   } pipe1_t;

   typedef struct packed {
      cpu_raw_request_t raw_req;
      pipe1_t           pipe1;
      logic             ready_to_send;
   } pipe3_t;
endpackage

// File: rtl/cpu_resp_tx.sv
// Response transmitter: turns completed pipe3 entries into CPU responses, buffers them
// in a small FIFO and drives them out on a valid/ready channel.
module cpu_resp_tx
   import design_params::*;
#(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  pipe3_t                in_req,
   input  logic [DATA_WIDTH-1:0] in_rd_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [REQ_ID-1:0]     resp_req_id,
   output logic [OP-1:0]         resp_op,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [1:0]            resp_status,
   output logic                  dup_id_err,
   output logic [CNT_WIDTH-1:0]  resp_count
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [REQ_ID-1:0]     req_id;
      logic [OP-1:0]         op;
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            status;
   } resp_t;

   resp_t                mem_q [DEPTH];
   resp_t                mem_d [DEPTH];
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]          count_q, count_d;
   logic                 dup_q, dup_d;
   logic [CNT_WIDTH-1:0] sent_q, sent_d;

   logic                 full, empty, push, pop, id_match;
   logic [PW-1:0]        offs;
   resp_t                new_entry;

   assign full       = (count_q == (PW+1)'(DEPTH));
   assign empty      = (count_q == '0);
   // A full FIFO refuses entries even when the head pops in the same cycle.
   assign in_ready   = rst_n & ~full & in_req.ready_to_send;
   assign push       = in_valid & in_ready;
   assign resp_valid = ~empty;
   assign pop        = resp_valid & resp_ready;

   assign resp_req_id = mem_q[rd_ptr_q].req_id;
   assign resp_op     = mem_q[rd_ptr_q].op;
   assign resp_data   = mem_q[rd_ptr_q].data;
   assign resp_status = mem_q[rd_ptr_q].status;
   assign dup_id_err  = dup_q;
   assign resp_count  = sent_q;

   always_comb begin
      new_entry.req_id = in_req.raw_req.req_id;
      new_entry.op     = in_req.raw_req.op;
      new_entry.data   = '0;
      new_entry.status = 2'b10;
      if (in_req.raw_req.op == OP'(0)) begin
         new_entry.data   = in_rd_data;
         new_entry.status = in_req.pipe1.hit ? 2'b00 : 2'b01;
      end else if (in_req.raw_req.op == OP'(1)) begin
         new_entry.status = in_req.pipe1.hit ? 2'b00 : 2'b01;
      end
   end

   // Live slots sit at offsets 0..count-1 from the read pointer; the head is
   // excluded when it leaves in the same cycle.
   always_comb begin
      id_match = 1'b0;
      offs     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr_q;
         if (({1'b0, offs} < count_q) && !(pop && (offs == '0)) &&
             (mem_q[i].req_id == new_entry.req_id))
            id_match = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      dup_d    = dup_q;
      sent_d   = sent_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         if (id_match) dup_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         sent_d   = sent_q + CNT_WIDTH'(1);
      end
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!push && pop) count_d = count_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dup_q    <= 1'b0;
         sent_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dup_q    <= dup_d;
         sent_q   <= sent_d;
      end
   end
endmodule

// File: tb/tb_cpu_resp_tx.sv
// Bench for cpu_resp_tx: directed vector table, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_cpu_resp_tx;
   import design_params::*;

   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready;
   pipe3_t            in_req;
   logic [31:0]       in_rd_data;
   logic              resp_valid, resp_ready;
   logic [3:0]        resp_req_id;
   logic [1:0]        resp_op;
   logic [31:0]       resp_data;
   logic [1:0]        resp_status;
   logic              dup_id_err;
   logic [CW-1:0]     resp_count;

   logic              rts, hit;
   logic [1:0]        op;
   logic [3:0]        id;

   always #5 clk = ~clk;

   always_comb begin
      in_req.raw_req.req_id = id;
      in_req.raw_req.op     = op;
      in_req.pipe1.hit      = hit;
      in_req.ready_to_send  = rts;
   end

   cpu_resp_tx #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req), .in_rd_data(in_rd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_req_id(resp_req_id), .resp_op(resp_op), .resp_data(resp_data),
      .resp_status(resp_status), .dup_id_err(dup_id_err), .resp_count(resp_count)
   );

   typedef struct {
      logic [3:0]  id;
      logic [1:0]  op;
      logic [31:0] data;
      logic [1:0]  st;
   } m_t;

   typedef struct {
      bit        iv, rts, hit;
      bit [1:0]  op;
      bit [3:0]  id;
      bit [31:0] rd;
      bit        rr;
      bit        e_valid, e_iready;
      bit [3:0]  e_id;
      bit [1:0]  e_op;
      bit [31:0] e_data;
      bit [1:0]  e_st;
      int        e_cnt;
   } vec_t;

   int         n_total = 0;
   int         n_pass  = 0;
   bit         model_on = 0;
   m_t         mq[$];
   int         m_cnt = 0;
   bit         m_dup = 0;
   logic [3:0] popped[$];
   vec_t       vecs[7];

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
   endtask

   task automatic drive(input bit iv, input bit r, input bit h, input bit [1:0] o,
                        input bit [3:0] i, input bit [31:0] d, input bit rr);
      in_valid = iv; rts = r; hit = h; op = o; id = i; in_rd_data = d; resp_ready = rr;
   endtask

   task automatic check_model();
      bit exp_ready;
      exp_ready = rst_n && (mq.size() < DEPTH) && rts;
      chk("m_in_ready", in_ready, exp_ready);
      chk("m_resp_valid", resp_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("m_req_id", resp_req_id, mq[0].id);
         chk("m_op", resp_op, mq[0].op);
         chk("m_data", resp_data, mq[0].data);
         chk("m_status", resp_status, mq[0].st);
      end
      chk("m_resp_count", resp_count, m_cnt);
      chk("m_dup", dup_id_err, m_dup);
   endtask

   task automatic update_model();
      bit do_pop, do_push;
      m_t e;
      if (!rst_n) begin
         mq.delete(); m_cnt = 0; m_dup = 0; model_on = 1;
      end else if (model_on) begin
         do_pop  = (mq.size() != 0) && resp_ready;
         do_push = in_valid && (mq.size() < DEPTH) && rts;
         e.id   = id;
         e.op   = op;
         e.data = (op == 2'd0) ? in_rd_data : 32'h0;
         e.st   = (op >= 2'd2) ? 2'b10 : (hit ? 2'b00 : 2'b01);
         if (do_push)
            for (int j = do_pop ? 1 : 0; j < mq.size(); j++)
               if (mq[j].id == id) m_dup = 1;
         if (do_pop) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
         if (do_push) mq.push_back(e);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (model_on) check_model();
      if (rst_n && resp_valid && resp_ready) popped.push_back(resp_req_id);
      update_model();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      drive(1, 1, 1, 2'd0, 4'd1, 32'h1234, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      tick();
      tick();
      chk("t1_resp_valid", resp_valid, 0);
      chk("t1_in_ready", in_ready, 0);
      chk("t1_resp_count", resp_count, 0);
      chk("t1_dup", dup_id_err, 0);
      chk("t1_resp_data", resp_data, 0);
      rst_n = 1'b1;

      //            iv rts hit op  id   rd            rr  val rdy eid eop edata  est cnt
      vecs[0] = '{1, 1, 1, 2'd0, 4'd3, 32'hDEADBEEF, 0,  0,  1,  0,  0,  0,     0,  0};
      vecs[1] = '{0, 1, 0, 2'd0, 4'd0, 32'h0,        1,  1,  1,  3,  0,  32'hDEADBEEF, 0, 0};
      vecs[2] = '{1, 1, 0, 2'd1, 4'd5, 32'h55,       0,  0,  1,  0,  0,  0,     0,  1};
      vecs[3] = '{1, 1, 1, 2'd3, 4'd6, 32'hAAAA,     1,  1,  1,  5,  1,  0,     1,  1};
      vecs[4] = '{0, 1, 0, 2'd0, 4'd0, 32'h0,        1,  1,  1,  6,  3,  0,     2,  2};
      vecs[5] = '{1, 0, 1, 2'd0, 4'd9, 32'h77,       1,  0,  0,  0,  0,  0,     0,  3};
      vecs[6] = '{0, 1, 0, 2'd0, 4'd0, 32'h0,        1,  0,  1,  0,  0,  0,     0,  3};
      for (int v = 0; v < 7; v++) begin
         drive(vecs[v].iv, vecs[v].rts, vecs[v].hit, vecs[v].op, vecs[v].id,
               vecs[v].rd, vecs[v].rr);
         #1;
         chk($sformatf("v%0d_valid", v), resp_valid, vecs[v].e_valid);
         chk($sformatf("v%0d_in_ready", v), in_ready, vecs[v].e_iready);
         chk($sformatf("v%0d_count", v), resp_count, vecs[v].e_cnt);
         if (vecs[v].e_valid) begin
            chk($sformatf("v%0d_id", v), resp_req_id, vecs[v].e_id);
            chk($sformatf("v%0d_op", v), resp_op, vecs[v].e_op);
            chk($sformatf("v%0d_data", v), resp_data, vecs[v].e_data);
            chk($sformatf("v%0d_status", v), resp_status, vecs[v].e_st);
         end
         tick();
      end

      // Backpressure: four fit, the fifth is held until space appears.
      popped.delete();
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, 2'd0, 4'(k), 32'(k * 32'h111), 0);
         #1;
         chk("t3_in_ready", in_ready, k < 4);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      chk("t3_full_pop_in_ready", in_ready, 0);
      tick();
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("t3_pop_total", popped.size(), 5);
      for (int k = 0; k < 5 && k < popped.size(); k++)
         chk($sformatf("t3_order%0d", k), popped[k], k);

      // Duplicate id stays flagged after the queue drains.
      chk("t5_dup_before", dup_id_err, 0);
      drive(1, 1, 0, 2'd0, 4'd2, 32'h22, 0); tick();
      drive(1, 1, 1, 2'd1, 4'd2, 32'h23, 0); tick();
      in_valid = 1'b0;
      #1;
      chk("t5_dup_set", dup_id_err, 1);
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("t5_dup_sticky", dup_id_err, 1);
      chk("t5_drained", resp_valid, 0);

      // Push and pop in the same cycle with one entry queued.
      drive(1, 1, 1, 2'd0, 4'd7, 32'h7007, 0); tick();
      c0 = m_cnt;
      drive(1, 1, 1, 2'd0, 4'd8, 32'h8008, 1); tick();
      drive(0, 1, 0, 2'd0, 4'd0, 32'h0, 0);
      #1;
      chk("t6_valid", resp_valid, 1);
      chk("t6_head_id", resp_req_id, 8);
      chk("t6_head_data", resp_data, 32'h8008);
      chk("t6_count", resp_count, (c0 + 1) % (1 << CW));
      resp_ready = 1'b1; tick();
      resp_ready = 1'b0; #1;
      chk("t6_single_entry", resp_valid, 0);

      // Randomized traffic with a mid-run reset.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 2) != 0);
         rst_n = (n != 200);
         tick();
         if (n == 200) begin
            rst_n = 1'b1;
            #1;
            chk("rand_reset_empty", resp_valid, 0);
            chk("rand_reset_count", resp_count, 0);
            chk("rand_reset_dup", dup_id_err, 0);
         end
      end
      drive(0, 1, 0, 2'd0, 4'd0, 32'h0, 1);
      for (int k = 0; k < 8; k++) tick();
      chk("final_empty", resp_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
